// File: rtl/ddr3_arb_pkg.sv
// Shared command encodings and FSM states for the DDR3 port arbiter.
package ddr3_arb_pkg;

  localparam logic [2:0] DDR_CMD_WRITE = 3'b000;
  localparam logic [2:0] DDR_CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2
  } arb_state_e;

  function automatic int port_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ddr3_tag_fifo.sv
// In-order read tag FIFO; head is valid whenever empty_o is low.
module ddr3_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Round-robin N-port arbiter in front of ddr3_rw: write data is locked
// to the winner, read beats are steered back via an in-order tag FIFO.
module ddr3_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int UI_WIDTH   = 512,
  parameter int ADDR_WIDTH = 29,
  parameter int SIZE_WIDTH = 10,
  parameter int TAG_DEPTH  = 8
) (
  input  logic                           ui_clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS*3-1:0]          p_cmd,
  input  logic [NUM_PORTS-1:0]            p_cmd_valid,
  output logic [NUM_PORTS-1:0]            p_cmd_rdy,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
  input  logic [NUM_PORTS*SIZE_WIDTH-1:0] p_size,
  input  logic [NUM_PORTS*UI_WIDTH-1:0]   p_wdf_data,
  input  logic [NUM_PORTS-1:0]            p_wdf_valid,
  output logic [NUM_PORTS-1:0]            p_wdf_rdy,
  output logic [UI_WIDTH-1:0]             p_rd_data,
  output logic [NUM_PORTS-1:0]            p_rd_valid,
  output logic [2:0]                      m_cmd,
  output logic                            m_cmd_valid,
  input  logic                            m_cmd_rdy,
  output logic [ADDR_WIDTH-1:0]           m_addr,
  output logic [SIZE_WIDTH-1:0]           m_size,
  output logic [UI_WIDTH-1:0]             m_wdf_data,
  output logic                            m_wdf_valid,
  input  logic                            m_wdf_rdy,
  input  logic [UI_WIDTH-1:0]             m_rd_data,
  input  logic                            m_rd_valid,
  output logic                            err_sticky
);

  localparam int PW = port_w(NUM_PORTS);
  localparam int EW = PW + SIZE_WIDTH;
  localparam logic [SIZE_WIDTH-1:0] ONE = SIZE_WIDTH'(1);

  logic [2:0]            cmd_a   [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_PORTS];
  logic [SIZE_WIDTH-1:0] size_a  [NUM_PORTS];
  logic [UI_WIDTH-1:0]   wdata_a [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign cmd_a[i]   = p_cmd[i*3 +: 3];
    assign addr_a[i]  = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign size_a[i]  = p_size[i*SIZE_WIDTH +: SIZE_WIDTH];
    assign wdata_a[i] = p_wdf_data[i*UI_WIDTH +: UI_WIDTH];
  end

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic [PW-1:0]         last_q, last_d;
  logic [2:0]            mcmd_q, mcmd_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [SIZE_WIDTH-1:0] msize_q, msize_d;
  logic                  mvalid_q, mvalid_d;
  logic [SIZE_WIDTH-1:0] beats_q, beats_d;
  logic [SIZE_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [SIZE_WIDTH-1:0] rcnt_q, rcnt_d;
  logic                  err_q, err_d;

  logic                  fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [EW-1:0]         fifo_head;
  logic [PW-1:0]         head_tag;
  logic [SIZE_WIDTH-1:0] head_beats;
  logic [NUM_PORTS-1:0]  elig;
  logic [PW-1:0]         sel;
  logic                  rd_hit;

  function automatic logic [PW-1:0] rr_pick(
    input logic [NUM_PORTS-1:0] req,
    input logic [PW-1:0]        last
  );
    logic [PW-1:0] pick;
    logic          hit;
    int            idx;
    pick = '0;
    hit  = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last) + k) % NUM_PORTS;
      if (!hit && req[idx]) begin
        pick = PW'(idx);
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [SIZE_WIDTH-1:0] beats_of(
    input logic [SIZE_WIDTH-1:0] sz
  );
    return (sz == '0) ? ONE : sz;
  endfunction

  // Reads are only eligible while a tag slot is free.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      elig[i] = p_cmd_valid[i] &&
                !(cmd_a[i][0] == DDR_CMD_READ[0] && fifo_full);
    end
  end

  assign sel = rr_pick(elig, last_q);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    mcmd_d      = mcmd_q;
    maddr_d     = maddr_q;
    msize_d     = msize_q;
    mvalid_d    = mvalid_q;
    beats_d     = beats_q;
    wcnt_d      = wcnt_q;
    fifo_push   = 1'b0;
    p_cmd_rdy   = '0;
    p_wdf_rdy   = '0;
    m_wdf_valid = 1'b0;
    m_wdf_data  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          grant_d  = sel;
          mcmd_d   = cmd_a[sel];
          maddr_d  = addr_a[sel];
          msize_d  = size_a[sel];
          beats_d  = beats_of(size_a[sel]);
          mvalid_d = 1'b1;
          state_d  = ST_CMD;
        end
      end
      ST_CMD: begin
        if (m_cmd_rdy) begin
          p_cmd_rdy[grant_q] = 1'b1;
          mvalid_d = 1'b0;
          last_d   = grant_q;
          if (mcmd_q[0] == DDR_CMD_READ[0]) begin
            fifo_push = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            wcnt_d  = beats_q;
            state_d = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        m_wdf_data         = wdata_a[grant_q];
        m_wdf_valid        = p_wdf_valid[grant_q];
        p_wdf_rdy[grant_q] = m_wdf_rdy;
        if (p_wdf_valid[grant_q] && m_wdf_rdy) begin
          wcnt_d = wcnt_q - ONE;
          if (wcnt_q == ONE) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign head_tag   = fifo_head[EW-1 -: PW];
  assign head_beats = fifo_head[SIZE_WIDTH-1:0];
  assign rd_hit     = m_rd_valid && !fifo_empty;
  assign p_rd_data  = rd_hit ? m_rd_data : '0;
  assign fifo_pop   = rd_hit && ((rcnt_q + ONE) == head_beats);

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      p_rd_valid[i] = rd_hit && (head_tag == PW'(i));
    end
  end

  always_comb begin
    rcnt_d = rcnt_q;
    err_d  = err_q | (m_rd_valid && fifo_empty);
    if (rd_hit) rcnt_d = fifo_pop ? '0 : rcnt_q + ONE;
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      last_q   <= PW'(NUM_PORTS - 1);
      mcmd_q   <= '0;
      maddr_q  <= '0;
      msize_q  <= '0;
      mvalid_q <= 1'b0;
      beats_q  <= '0;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      mcmd_q   <= mcmd_d;
      maddr_q  <= maddr_d;
      msize_q  <= msize_d;
      mvalid_q <= mvalid_d;
      beats_q  <= beats_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      err_q    <= err_d;
    end
  end

  assign m_cmd       = mcmd_q;
  assign m_addr      = maddr_q;
  assign m_size      = msize_q;
  assign m_cmd_valid = mvalid_q;
  assign err_sticky  = err_q;

  ddr3_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (EW)
  ) u_tag_fifo (
    .clk_i   (ui_clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .din_i   ({grant_q, beats_q}),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: grants, write lock, read steering.
module tb_ddr3_port_arbiter;

  localparam int NP = 4;
  localparam int UI = 64;
  localparam int AW = 29;
  localparam int SW = 10;
  localparam int TD = 8;

  logic              ui_clk = 1'b0;
  logic              rst_n;
  logic [NP*3-1:0]   p_cmd;
  logic [NP-1:0]     p_cmd_valid;
  logic [NP-1:0]     p_cmd_rdy;
  logic [NP*AW-1:0]  p_addr;
  logic [NP*SW-1:0]  p_size;
  logic [NP*UI-1:0]  p_wdf_data;
  logic [NP-1:0]     p_wdf_valid;
  logic [NP-1:0]     p_wdf_rdy;
  logic [UI-1:0]     p_rd_data;
  logic [NP-1:0]     p_rd_valid;
  logic [2:0]        m_cmd;
  logic              m_cmd_valid;
  logic              m_cmd_rdy;
  logic [AW-1:0]     m_addr;
  logic [SW-1:0]     m_size;
  logic [UI-1:0]     m_wdf_data;
  logic              m_wdf_valid;
  logic              m_wdf_rdy;
  logic [UI-1:0]     m_rd_data;
  logic              m_rd_valid;
  logic              err_sticky;

  int checks = 0;
  int errors = 0;

  always #5 ui_clk = ~ui_clk;

  ddr3_port_arbiter #(
    .NUM_PORTS  (NP),
    .UI_WIDTH   (UI),
    .ADDR_WIDTH (AW),
    .SIZE_WIDTH (SW),
    .TAG_DEPTH  (TD)
  ) dut (
    .ui_clk      (ui_clk),
    .rst_n       (rst_n),
    .p_cmd       (p_cmd),
    .p_cmd_valid (p_cmd_valid),
    .p_cmd_rdy   (p_cmd_rdy),
    .p_addr      (p_addr),
    .p_size      (p_size),
    .p_wdf_data  (p_wdf_data),
    .p_wdf_valid (p_wdf_valid),
    .p_wdf_rdy   (p_wdf_rdy),
    .p_rd_data   (p_rd_data),
    .p_rd_valid  (p_rd_valid),
    .m_cmd       (m_cmd),
    .m_cmd_valid (m_cmd_valid),
    .m_cmd_rdy   (m_cmd_rdy),
    .m_addr      (m_addr),
    .m_size      (m_size),
    .m_wdf_data  (m_wdf_data),
    .m_wdf_valid (m_wdf_valid),
    .m_wdf_rdy   (m_wdf_rdy),
    .m_rd_data   (m_rd_data),
    .m_rd_valid  (m_rd_valid),
    .err_sticky  (err_sticky)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    p_cmd       = '0;
    p_cmd_valid = '0;
    p_addr      = '0;
    p_size      = '0;
    p_wdf_data  = '0;
    p_wdf_valid = '0;
    m_cmd_rdy   = 1'b0;
    m_wdf_rdy   = 1'b0;
    m_rd_data   = '0;
    m_rd_valid  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_port(input int i, input logic [2:0] cmd,
                          input logic [AW-1:0] addr,
                          input logic [SW-1:0] size);
    p_cmd[i*3 +: 3]   = cmd;
    p_addr[i*AW +: AW] = addr;
    p_size[i*SW +: SW] = size;
  endtask

  task automatic wait_grant(input int budget, output logic [NP-1:0] g);
    g = '0;
    #1;
    for (int i = 0; i < budget; i++) begin
      if (p_cmd_rdy != '0) begin
        g = p_cmd_rdy;
        break;
      end
      tick();
    end
  endtask

  task automatic wr_beats(input int port, input int maxhs,
                          input int cycles, input bit toggle,
                          output int hs);
    logic [63:0] base;
    base = 64'h1000 * (port + 1);
    hs   = 0;
    p_wdf_valid[port] = 1'b1;
    for (int c = 0; c < cycles && hs < maxhs; c++) begin
      m_wdf_rdy = toggle ? ((c % 2) == 1) : 1'b1;
      p_wdf_data[port*UI +: UI] = base + 64'(hs);
      #1;
      if (m_wdf_valid && m_wdf_rdy) begin
        chk("wr_data", m_wdf_data, base + 64'(hs));
        chk("wr_rdy_lock", p_wdf_rdy, 64'(1 << port));
        hs++;
      end
      tick();
    end
    p_wdf_valid[port] = 1'b0;
    m_wdf_rdy = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0] g;
    int            hs;
    int            acc;
    int            rr_exp[5];
    rr_exp = '{0, 1, 2, 3, 0};

    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valids", {m_cmd_valid, m_wdf_valid, p_cmd_rdy, p_wdf_rdy,
                       p_rd_valid, err_sticky}, 0);
    chk("rst_buses", {m_cmd, m_size, m_addr}, 0);
    chk("rst_wdata", m_wdf_data, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single write, port 1, 4 beats
    set_port(1, 3'b000, 29'h1234, 10'd4);
    p_cmd_valid[1] = 1'b1;
    m_cmd_rdy = 1'b1;
    m_wdf_rdy = 1'b1;
    p_wdf_valid[0] = 1'b1;
    p_wdf_data[0 +: UI] = 64'hdead;
    #1;
    chk("sw_no_early_valid", m_cmd_valid, 0);
    tick();
    chk("sw_cmd_valid", m_cmd_valid, 1);
    chk("sw_cmd", m_cmd, 0);
    chk("sw_addr", m_addr, 29'h1234);
    chk("sw_size", m_size, 4);
    chk("sw_cmd_rdy", p_cmd_rdy, 4'b0010);
    p_cmd_valid[1] = 1'b0;
    tick();
    wr_beats(1, 100, 8, 1'b0, hs);
    chk("sw_beats", hs, 4);
    p_wdf_valid[0] = 1'b0;
    chk("sw_idle", m_cmd_valid, 0);

    // round robin over size-1 reads
    do_reset();
    for (int i = 0; i < NP; i++) set_port(i, 3'b001, AW'(32'h100 * (i + 1)), 10'd1);
    p_cmd_valid = '1;
    m_cmd_rdy = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_grant(6, g);
      chk("rr_grant", g, 64'(1 << rr_exp[n]));
      chk("rr_addr", m_addr, 64'(32'h100 * (rr_exp[n] + 1)));
      if (n == 4) p_cmd_valid = '0;
      tick();
    end
    for (int n = 0; n < 5; n++) begin
      m_rd_valid = 1'b1;
      m_rd_data  = 64'hd0 + 64'(n);
      #1;
      chk("rr_rd_valid", p_rd_valid, 64'(1 << rr_exp[n]));
      chk("rr_rd_data", p_rd_data, 64'hd0 + 64'(n));
      tick();
    end
    m_rd_valid = 1'b1;
    #1;
    chk("empty_rd_valid", p_rd_valid, 0);
    tick();
    m_rd_valid = 1'b0;
    chk("empty_err", err_sticky, 1);

    // command backpressure and toggling write ready
    do_reset();
    set_port(2, 3'b000, 29'h2222, 10'd8);
    p_cmd_valid[2] = 1'b1;
    tick();
    p_cmd_valid[2] = 1'b0;
    p_addr[2*AW +: AW] = 29'h3333;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_hold", {m_cmd_valid, m_cmd, m_size, m_addr, p_cmd_rdy},
          {1'b1, 3'b000, 10'd8, 29'h2222, 4'b0000});
      tick();
    end
    m_cmd_rdy = 1'b1;
    #1;
    chk("bp_cmd_rdy", p_cmd_rdy, 4'b0100);
    tick();
    wr_beats(2, 100, 40, 1'b1, hs);
    chk("bp_beats", hs, 8);
    p_wdf_valid[2] = 1'b1;
    #1;
    chk("bp_no_extra", m_wdf_valid, 0);
    p_wdf_valid[2] = 1'b0;

    // size 0 write is one beat
    set_port(0, 3'b000, 29'h0500, 10'd0);
    p_cmd_valid[0] = 1'b1;
    wait_grant(6, g);
    chk("sz0_grant", g, 4'b0001);
    chk("sz0_size", m_size, 0);
    p_cmd_valid[0] = 1'b0;
    tick();
    wr_beats(0, 100, 6, 1'b0, hs);
    chk("sz0_beats", hs, 1);

    // tag FIFO full: reads blocked, writes still granted
    set_port(0, 3'b001, 29'h0600, 10'd1);
    p_cmd_valid[0] = 1'b1;
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (p_cmd_rdy[0]) acc++;
      tick();
    end
    chk("full_accepts", acc, TD);
    p_cmd_valid[0] = 1'b0;
    set_port(2, 3'b001, 29'h2000, 10'd1);
    set_port(3, 3'b000, 29'h3000, 10'd1);
    p_cmd_valid = 4'b1100;
    wait_grant(6, g);
    chk("full_wr_wins", g, 4'b1000);
    p_cmd_valid[3] = 1'b0;
    tick();
    wr_beats(3, 1, 6, 1'b0, hs);
    chk("full_wr_beats", hs, 1);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (m_cmd_valid) acc++;
      tick();
    end
    chk("full_rd_blocked", acc, 0);
    m_rd_valid = 1'b1;
    m_rd_data  = 64'hbeef;
    #1;
    chk("full_pop_port", p_rd_valid, 4'b0001);
    tick();
    m_rd_valid = 1'b0;
    wait_grant(6, g);
    chk("full_rd_resume", g, 4'b0100);
    p_cmd_valid = '0;
    tick();

    // reset in the middle of a 6-beat write
    set_port(1, 3'b000, 29'h0777, 10'd6);
    p_cmd_valid[1] = 1'b1;
    wait_grant(6, g);
    chk("rm_grant", g, 4'b0010);
    p_cmd_valid[1] = 1'b0;
    tick();
    wr_beats(1, 2, 10, 1'b0, hs);
    chk("rm_beats", hs, 2);
    p_wdf_valid[1] = 1'b1;
    #1;
    chk("rm_pre_valid", m_wdf_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_valids", {m_wdf_valid, p_wdf_rdy, m_cmd_valid, p_cmd_rdy}, 0);
    chk("rm_buses", {m_addr, m_size, m_cmd}, 0);
    chk("rm_wdata", m_wdf_data, 0);
    tick();
    rst_n = 1'b1;
    p_wdf_valid = '0;
    tick();
    m_rd_valid = 1'b1;
    #1;
    chk("rm_fifo_flushed", p_rd_valid, 0);
    tick();
    m_rd_valid = 1'b0;
    set_port(0, 3'b000, 29'h0aaa, 10'd1);
    p_cmd_valid[0] = 1'b1;
    m_cmd_rdy = 1'b1;
    #1;
    chk("rm_no_early", m_cmd_valid, 0);
    tick();
    chk("rm_new_valid", m_cmd_valid, 1);
    chk("rm_new_addr", m_addr, 29'h0aaa);
    chk("rm_new_rdy", p_cmd_rdy, 4'b0001);
    p_cmd_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
